// File: rtl/dpdistram_fifo_ctrl.sv
// dpdistram_fifo_ctrl: single-clock FIFO controller that owns a dual-port
// distributed RAM. Writes go through RAM port A and reads are issued on port B.
// A small prefetch buffer hides the registered read latency so that the read
// side is a plain valid/ready stream that can sustain one word per cycle.
module dpdistram_fifo_ctrl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_wea,
    output logic                  ram_ena,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int OBUF_DEPTH = READ_LATENCY + 1;
    localparam int OB_PW      = $clog2(OBUF_DEPTH);
    // Wide enough for obuf_cnt + inflight_cnt before the pop is subtracted.
    localparam int OC_W       = $clog2(2 * OBUF_DEPTH + 1);
    localparam int CNT_W      = ADDR_WIDTH + 2;

    localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [OC_W-1:0]     OB_FULL  = OC_W'(OBUF_DEPTH);
    localparam logic [OB_PW-1:0]    OB_LAST  = OB_PW'(OBUF_DEPTH - 1);

    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     ram_cnt_q, ram_cnt_d;
    logic [READ_LATENCY-1:0] infl_q, infl_d;
    logic [DATA_WIDTH-1:0]   obuf_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   obuf_d [OBUF_DEPTH];
    logic [OB_PW-1:0]        ob_head_q, ob_head_d;
    logic [OB_PW-1:0]        ob_tail_q, ob_tail_d;
    logic [OC_W-1:0]         obuf_cnt_q, obuf_cnt_d;

    logic [OC_W-1:0] inflight_cnt;
    logic [OC_W-1:0] credit;
    logic            push;
    logic            pop;
    logic            issue;
    logic            ret;

    // Handshakes, read-issue credit check and RAM port drive.
    // NOTE: combinational blocks use blocking '=' so later lines see the values
    // computed above them; only clocked blocks use '<='.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OC_W'(infl_q[i]);
        end

        s_ready = !rst && (ram_cnt_q < RAM_FULL);
        m_valid = !rst && (obuf_cnt_q != '0);
        m_data  = obuf_q[ob_head_q];

        push = s_valid && s_ready;
        pop  = m_valid && m_ready;
        ret  = infl_q[READ_LATENCY-1];

        // A read may only be issued if its data is guaranteed a buffer slot,
        // counting words already buffered and reads still in the RAM pipeline.
        credit = obuf_cnt_q + inflight_cnt - OC_W'(pop);
        issue  = !rst && (ram_cnt_q != '0) && (credit < OB_FULL);

        ram_wea    = push;
        ram_ena    = push;
        ram_addra  = wr_ptr_q;
        ram_dina   = s_data;
        ram_enb    = issue;
        ram_addrb  = rd_ptr_q;
        ram_regceb = 1'b1;
        ram_rstb   = rst;

        count = CNT_W'(ram_cnt_q) + CNT_W'(inflight_cnt) + CNT_W'(obuf_cnt_q);
        empty = (count == '0);
        full  = (ram_cnt_q == RAM_FULL);
    end

    // Next-state logic for pointers, occupancy, read pipeline and prefetch buffer.
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        infl_d     = '0;
        obuf_d     = obuf_q;
        ob_head_d  = ob_head_q;
        ob_tail_d  = ob_tail_q;
        obuf_cnt_d = obuf_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH + 1)'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase

        infl_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            infl_d[i] = infl_q[i-1];
        end

        if (ret) begin
            obuf_d[ob_tail_q] = ram_doutb;
            ob_tail_d = (ob_tail_q == OB_LAST) ? '0 : ob_tail_q + OB_PW'(1);
        end
        if (pop) begin
            ob_head_d = (ob_head_q == OB_LAST) ? '0 : ob_head_q + OB_PW'(1);
        end
        obuf_cnt_d = obuf_cnt_q + OC_W'(ret) - OC_W'(pop);
    end

    // Control state: synchronous reset drops all stored and in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            infl_q     <= '0;
            ob_head_q  <= '0;
            ob_tail_q  <= '0;
            obuf_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            infl_q     <= infl_d;
            ob_head_q  <= ob_head_d;
            ob_tail_q  <= ob_tail_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end

    // Prefetch buffer storage.
    // NOTE: data storage is not reset; obuf_cnt_q guards every read of it.
    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end

endmodule

// File: doc/dpdistram_fifo_ctrl.md
Name: dpdistram_fifo_ctrl

Overview:
Synchronous FIFO controller that owns a dual-port distributed RAM instance: it writes through RAM port A and reads through RAM port B. It hides the RAM's registered read latency behind a small prefetch buffer, presenting valid/ready streams on both sides. It sits directly upstream and downstream of the dual-port distributed RAM wrapper, on one clock, with the wrapper in common-clock mode.

Parameters:
ADDR_WIDTH, 6, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 32, word width; must equal the RAM read and write widths (symmetric mode only)
READ_LATENCY, 2, RAM port-B read latency in cycles; legal range 1..3; must match the RAM instance
(derived) OBUF_DEPTH = READ_LATENCY+1, number of prefetch buffer entries

Ports:
clk  in  1  single clock; also drives the RAM clka
rst  in  1  synchronous, active-high reset
s_valid  in  1  write-side data valid
s_ready  out  1  write-side ready
s_data  in  DATA_WIDTH  write-side data
m_valid  out  1  read-side data valid
m_ready  in  1  read-side ready
m_data  out  DATA_WIDTH  read-side data (head of prefetch buffer)
ram_addra  out  ADDR_WIDTH  RAM write address (write pointer)
ram_dina  out  DATA_WIDTH  RAM write data (equals s_data)
ram_wea  out  1  RAM write enable
ram_ena  out  1  RAM port-A enable (equals ram_wea)
ram_addrb  out  ADDR_WIDTH  RAM read address (read pointer)
ram_enb  out  1  RAM port-B enable (read issue)
ram_regceb  out  1  constant 1
ram_rstb  out  1  equals rst
ram_doutb  in  DATA_WIDTH  RAM read data
count  out  ADDR_WIDTH+2  total words held: RAM words + in-flight reads + prefetch buffer words
empty  out  1  count == 0
full  out  1  RAM word count == DEPTH

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- State: wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH); ram_cnt (0..DEPTH); inflight valid shift register (READ_LATENCY stages); prefetch buffer of OBUF_DEPTH entries with its own pointers and obuf_cnt.
- Reset: all pointers, counts and valid stages clear to 0. m_valid=0, s_ready=0, ram_wea=0, ram_enb=0, count=0, empty=1, full=0. s_ready rises on the first cycle after rst deasserts.
- Reset mid-operation: all stored and in-flight data is dropped. Any RAM data returning after reset is ignored.
- Write: push = s_valid && s_ready, where s_ready = !rst && ram_cnt < DEPTH (combinational from registers).
  - On push: ram_wea=ram_ena=1, ram_addra=wr_ptr, ram_dina=s_data.
  - At the clock edge, wr_ptr increments (wrapping from DEPTH-1 to 0).
- Read issue: pop = m_valid && m_ready.
  - issue = ram_cnt>0 && (obuf_cnt + inflight_cnt - pop) < OBUF_DEPTH.
  - On issue: ram_enb=1 and ram_addrb=rd_ptr; rd_ptr increments; a 1 enters valid stage 1.
  - A word written at edge t can be issued no earlier than cycle t+1, so there is never a same-address read/write collision.
- Return: when the last valid stage is 1, ram_doutb is written into the prefetch buffer at that edge. By the credit rule, the buffer can never overflow.
- ram_cnt update: +1 on push only, -1 on issue only, unchanged on simultaneous push and issue.
- Output: m_valid = obuf_cnt>0; m_data = buffer head. Both are stable while m_valid && !m_ready.
- Latency (READ_LATENCY=2): a word pushed in cycle 0 produces m_valid in cycle 4 if the FIFO was empty.
- Throughput: with m_ready held high, sustains 1 word per cycle.
- Full: s_ready=0 when ram_cnt==DEPTH. Total capacity is DEPTH+OBUF_DEPTH words.
- Empty: empty=1 only when ram_cnt, inflight and obuf_cnt are all 0.
- Error cases: push while !s_ready is ignored; m_ready while !m_valid is ignored.

Test Plan:
- Reset then idle: after rst held 3 cycles, expect s_ready=1 one cycle after release, m_valid=0, empty=1, count=0, ram_enb never asserted.
- Single word: push 0xA5A5_0001 in cycle 0 with m_ready=1 -> ram_wea=1 with addra=0 in cycle 0, ram_enb=1 with addrb=0 in cycle 1, m_valid=1 with m_data=0xA5A5_0001 in cycle 4, empty=1 in cycle 5.
- Streaming: push 0..199 back-to-back with m_ready=1 -> output is 0..199 in order, one word per cycle after the 4-cycle fill, no gaps; both pointers wrap past 63 three times.
- Fill/backpressure: m_ready=0, push until s_ready=0 -> exactly 67 words accepted (64 RAM + 3 buffer), full=1, count=67; then m_ready=1 drains 67 words in order and empty=1.
- Random stalls: random s_valid/m_ready at 50% for 5000 cycles -> scoreboard order matches, count always equals accepted minus popped, m_data stable during a stall.
- Reset mid-stream: assert rst with 20 words stored and 2 reads in flight -> cycle after release m_valid=0, count=0; the next pushed word 0x1234 is the first word output.
